mul_dot_ctrl: RTL

- Sequencer and accumulator that sits upstream and downstream of the shift_add 4x4 multiplier.
- Accepts operand pairs over a valid/ready handshake and drives the multiplier's start/a/b.
- Captures p after a fixed latency and accumulates N_TERMS products into a dot-product sum.
- Presents the sum on a valid/ready output.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/mul_dot_acc.sv | 46 ++++
 rtl/mul_dot_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the mul_dot sequencer: FSM state encoding, default
// operand widths and the run-counter width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int A_W_DEF     = 4;
  localparam int B_W_DEF     = 4;
  localparam int P_W_DEF     = A_W_DEF + B_W_DEF;
  localparam int MUL_LAT_DEF = 5;

  // run_cnt spans 0..lat-1; keep at least one bit for lat=1.
  function automatic int run_cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mul_dot_acc.sv
// Dot-product accumulator with sticky carry-out flag.
// MUL_DOT_SAT_EN: saturate to all ones on carry-out instead of wrapping.
module mul_dot_acc
  import mul_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_clr,
  input  logic             i_add_en,
  input  logic [P_W-1:0]   i_p,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W:0]   w_sum;

  function automatic logic [ACC_W-1:0] acc_next(input logic [ACC_W:0] s);
`ifdef MUL_DOT_SAT_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  // One spare bit above the accumulator catches the carry-out.
  assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - P_W){1'b0}}, i_p};

  always_ff @(posedge clk) begin
    if (!n_rst || i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_add_en) begin
      r_acc <= acc_next(w_sum);
      if (w_sum[ACC_W]) r_ovf <= 1'b1;
    end
  end

  assign o_sum = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/mul_dot_ctrl.sv
// Sequencer around the shift_add multiplier: accepts operand pairs, runs the
// multiplier, accumulates N_TERMS products. MUL_DOT_SAT_EN selects saturation.
module mul_dot_ctrl
  import mul_pkg::*;
#(
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int P_W     = P_W_DEF,
  parameter int ACC_W   = 10,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  output logic             mul_start,
  output logic [A_W-1:0]   mul_a,
  output logic [B_W-1:0]   mul_b,
  input  logic [P_W-1:0]   mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int RC_W = run_cnt_w(MUL_LAT);
  localparam int TC_W = $clog2(N_TERMS + 1);

  state_t          r_state;
  logic [RC_W-1:0] r_run_cnt;
  logic [TC_W-1:0] r_term_cnt;
  logic            r_mul_start;
  logic [A_W-1:0]  r_mul_a;
  logic [B_W-1:0]  r_mul_b;
  logic            r_out_valid;
  logic            w_add_en;
  logic            w_clr;

  assign in_ready = (r_state == IDLE);
  assign w_add_en = (r_state == CAPT);
  assign w_clr    = (r_state == DONE) && out_ready;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_run_cnt   <= '0;
      r_term_cnt  <= '0;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mul_a     <= in_a;
            r_mul_b     <= in_b;
            r_run_cnt   <= '0;
            r_mul_start <= 1'b1;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (r_run_cnt == RC_W'(MUL_LAT - 1)) begin
            r_mul_start <= 1'b0;
            r_state     <= CAPT;
          end else begin
            r_run_cnt <= r_run_cnt + RC_W'(1);
          end
        end
        CAPT: begin
          r_term_cnt <= r_term_cnt + TC_W'(1);
          if (r_term_cnt == TC_W'(N_TERMS - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_term_cnt  <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The product is added on the CAPT cycle, after MUL_LAT cycles of start.
  mul_dot_acc #(
    .P_W  (P_W),
    .ACC_W(ACC_W)
  ) u_acc (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_clr   (w_clr),
    .i_add_en(w_add_en),
    .i_p     (mul_p),
    .o_sum   (out_sum),
    .o_ovf   (out_ovf)
  );

  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign out_valid = r_out_valid;

endmodule
